// File: rtl/seq_controller.sv
// Fetch/decode controller: registers program-memory instructions into ir and drives the sequencer's jump controls.
// Optional hardware loop counter (LDC/DJNZ) is built only when SEQ_CTRL_LOOP_EN is defined.
module seq_controller #(
   parameter logic [3:0] OP_JMP      = 4'hE,
   parameter logic [3:0] OP_JNZ      = 4'hF,
   parameter logic [3:0] OP_LDC      = 4'hC,
   parameter logic [3:0] OP_DJNZ     = 4'hB,
   parameter logic [3:0] OP_HALT     = 4'hD,
   parameter int         FLUSH_SLOTS = 1
) (
   input  logic       clk,
   input  logic       sync_reset,
   input  logic [7:0] pm_data,
   input  logic       alu_zero,
   input  logic       alu_zero_we,
   output logic       jmp,
   output logic       jmp_nz,
   output logic       dont_jmp,
   output logic [3:0] jmp_addr,
   output logic [7:0] ir,
   output logic       ir_valid,
   output logic       zflag,
   output logic [3:0] loop_cnt,
   output logic       halted
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] flush_cnt;
   logic [1:0] flush_cnt_next;
   logic [7:0] ir_next;
   logic       ir_valid_next;
   logic [3:0] opcode;
   logic       taken;
   logic       halt_op;

   assign opcode   = ir[7:4];
   assign jmp_addr = ir[3:0];
   assign halted   = (state == HALT);
   assign halt_op  = ir_valid && (opcode == OP_HALT);
   assign taken    = jmp || (jmp_nz && !dont_jmp);

   // Decode sees a bubble as a NOP, so nothing can jump while flushing or halted.
   always_comb begin
      jmp      = 1'b0;
      jmp_nz   = 1'b0;
      dont_jmp = zflag;
      if (ir_valid) begin
         if (opcode == OP_JMP) begin
            jmp = 1'b1;
         end else if (opcode == OP_JNZ) begin
            jmp_nz = 1'b1;
`ifdef SEQ_CTRL_LOOP_EN
         end else if (opcode == OP_DJNZ) begin
            jmp_nz   = 1'b1;
            dont_jmp = (loop_cnt <= 4'd1);
`else
         end else if ((opcode == OP_LDC) || (opcode == OP_DJNZ)) begin
            jmp    = 1'b0;
            jmp_nz = 1'b0;
`endif
         end
      end
   end

   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      ir_next        = ir;
      ir_valid_next  = ir_valid;
      case (state)
         RUN: begin
            if (halt_op) begin
               state_next    = HALT;
               ir_next       = 8'h00;
               ir_valid_next = 1'b0;
            end else if (taken) begin
               // The wrong-path fetch arriving now is the first bubble.
               state_next     = FLUSH;
               flush_cnt_next = 2'(FLUSH_SLOTS - 1);
               ir_next        = 8'h00;
               ir_valid_next  = 1'b0;
            end else begin
               ir_next       = pm_data;
               ir_valid_next = 1'b1;
            end
         end
         FLUSH: begin
            if (flush_cnt == 2'd0) begin
               state_next    = RUN;
               ir_next       = pm_data;
               ir_valid_next = 1'b1;
            end else begin
               flush_cnt_next = flush_cnt - 2'd1;
               ir_next        = 8'h00;
               ir_valid_next  = 1'b0;
            end
         end
         HALT: begin
            ir_next       = 8'h00;
            ir_valid_next = 1'b0;
         end
         default: begin
            state_next    = RUN;
            ir_next       = 8'h00;
            ir_valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state     <= RUN;
         flush_cnt <= 2'd0;
         ir        <= 8'h00;
         ir_valid  <= 1'b0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
         ir        <= ir_next;
         ir_valid  <= ir_valid_next;
      end
   end

   // JNZ decodes from the current flag; a write this cycle shows up next cycle.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         zflag <= 1'b0;
      end else if (alu_zero_we) begin
         zflag <= alu_zero;
      end
   end

`ifdef SEQ_CTRL_LOOP_EN
   // Counter saturates at zero so DJNZ on 0 or 1 falls through without wrapping.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         loop_cnt <= 4'h0;
      end else if (ir_valid && (opcode == OP_LDC)) begin
         loop_cnt <= ir[3:0];
      end else if (ir_valid && (opcode == OP_DJNZ)) begin
         loop_cnt <= (loop_cnt >= 4'd2) ? (loop_cnt - 4'd1) : 4'h0;
      end
   end
`else
   assign loop_cnt = 4'h0;
`endif

endmodule
